// File: rtl/byte_word_packer32.sv
// byte_word_packer32
// Packs an 8-bit valid/ready byte stream into 32-bit words for the
// endian/bit-order swap stage. Each word is presented on a one-entry
// registered output slot together with a last-word flag and the number of
// real bytes it carries. A word closed early by in_last has its unfilled
// lanes set to PAD_BYTE.
//
// Parameters
//   FIRST_BYTE_MSB  1: first byte of a word in [31:24]; 0: first byte in [7:0]
//   PAD_BYTE        fill value for lanes not written before in_last
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous, active-high reset
//   in_byte    in   [7:0] input data byte
//   in_valid   in   in_byte valid
//   in_last    in   in_byte is the final byte of a packet
//   in_ready   out  byte accepted this cycle when in_valid is high
//   out_word   out  [31:0] packed word
//   out_valid  out  out_word valid
//   out_last   out  out_word ends a packet
//   out_bytes  out  [2:0] real bytes in out_word, 1..4
//   out_ready  in   downstream accepts out_word
//   fill_cnt   out  [1:0] bytes held in the assembly register
module byte_word_packer32 #(
  parameter int         FIRST_BYTE_MSB = 1,
  parameter logic [7:0] PAD_BYTE       = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] out_word,
  output logic        out_valid,
  output logic        out_last,
  output logic [2:0]  out_bytes,
  input  logic        out_ready,
  output logic [1:0]  fill_cnt
);

  logic [31:0] acc_q, acc_d;
  logic [1:0]  fill_q, fill_d;
  logic [31:0] out_word_q, out_word_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic [2:0]  out_bytes_q, out_bytes_d;

  logic        slot_free;
  logic        accept;
  logic        close_word;
  logic [31:0] merged;

  // A byte that would close a word needs the output slot; bytes that only
  // fill lanes 0..2 can be taken while the slot is still stalled.
  assign slot_free  = !out_valid_q || out_ready;
  assign in_ready   = slot_free || ((fill_q != 2'd3) && !in_last);
  assign accept     = in_valid && in_ready;
  assign close_word = accept && ((fill_q == 2'd3) || in_last);

  // Assembly register with the incoming byte dropped into lane fill_q.
  // Lanes not yet written still hold PAD_BYTE from the last clear.
  always_comb begin
    merged = acc_q;
    for (int k = 0; k < 4; k++) begin
      if (fill_q == 2'(k)) begin
        if (FIRST_BYTE_MSB != 0) merged[31-8*k -: 8] = in_byte;
        else                     merged[8*k+7 -: 8]  = in_byte;
      end
    end
  end

  always_comb begin
    acc_d       = acc_q;
    fill_d      = fill_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_bytes_d = out_bytes_q;

    // Drain; a close in the same cycle overrides below for zero bubble.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (accept) begin
      if (close_word) begin
        out_word_d  = merged;
        out_bytes_d = {1'b0, fill_q} + 3'd1;
        out_last_d  = in_last;
        out_valid_d = 1'b1;
        acc_d       = {4{PAD_BYTE}};
        fill_d      = 2'd0;
      end else begin
        acc_d  = merged;
        fill_d = fill_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= {4{PAD_BYTE}};
      fill_q      <= 2'd0;
      out_word_q  <= 32'h0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_bytes_q <= 3'd0;
    end else begin
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_bytes_q <= out_bytes_d;
    end
  end

  assign out_word  = out_word_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_bytes = out_bytes_q;
  assign fill_cnt  = fill_q;

endmodule
